// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests to instruction memory, a small
// registered FIFO of returned words toward decode, and wrong-path discard after redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    localparam int              CW        = $clog2(DEPTH + 1);
    localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [31:0]     WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]   pc;
    logic [31:0]   head_pc;
    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic          credit_ok;
    logic          req_fire;
    logic          rsp_take;
    logic          push;
    logic          pop;
    logic [31:0]   target_word;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] wr_ptr_nxt;

    // Credits cover both in-flight requests and buffered words, so a push never finds the FIFO full.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take    = imem_rsp_valid && (outstanding != '0);
    assign push        = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign if_valid    = (fifo_count != '0) && !redirect_valid;
    assign pop         = if_valid && id_ready;

    assign if_instr    = if_valid ? fifo_mem[rd_ptr] : NOP_INSTR;
    assign if_pc       = head_pc;
    assign if_pc4      = head_pc + 32'd4;

    assign target_word = redirect_target & WORD_MASK;
    assign rd_ptr_nxt  = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    assign wr_ptr_nxt  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            head_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({req_fire, rsp_take})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc         <= target_word;
                head_pc    <= target_word;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
                drop_cnt   <= outstanding - (rsp_take ? CW'(1) : CW'(0));
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (rsp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr_nxt;
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr_nxt;
                    head_pc <= head_pc + 32'd4;
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CW'(1);
                    2'b01:   fifo_count <= fifo_count - CW'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

endmodule
